// File: rtl/ym_rom_arbiter.sv
// Shares one SDRAM audio-ROM port between YM ADPCM channels A and B.
// Each channel has a one-word read cache; misses are fetched round-robin over a toggle handshake.
module ym_rom_arbiter #(
  parameter logic [26:0] BASE_A = 27'h0000000,
  parameter logic [26:0] BASE_B = 27'h0800000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ya_oe_n,
  input  logic [23:0] ya_addr,
  output logic [7:0]  ya_data,
  output logic        ya_ready,
  input  logic        yb_oe_n,
  input  logic [23:0] yb_addr,
  output logic [7:0]  yb_data,
  output logic        yb_ready,
  output logic [26:0] sdr_address,
  input  logic [15:0] sdr_data,
  output logic        sdr_req,
  input  logic        sdr_ack
);

  // state | meaning
  // IDLE  | no fetch outstanding; grant a miss once the handshake is quiet
  // WAIT  | fetch issued; fill the granted cache when sdr_ack == sdr_req
  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_next;
  logic        valid_a, valid_b;
  logic [22:0] tag_a, tag_b, fetch_tag;
  logic [15:0] word_a, word_b;
  logic        grant, last_grant;   // 0 = A, 1 = B
  logic        discard;
  logic        hit_a, hit_b, inflight_a, inflight_b, miss_a, miss_b;
  logic        issue, sel, fill;

  assign hit_a = valid_a && (tag_a == ya_addr[23:1]);
  assign hit_b = valid_b && (tag_b == yb_addr[23:1]);
  assign inflight_a = (state == WAIT) && !grant && (fetch_tag == ya_addr[23:1]);
  assign inflight_b = (state == WAIT) &&  grant && (fetch_tag == yb_addr[23:1]);
  assign miss_a = !ya_oe_n && !hit_a && !inflight_a;
  assign miss_b = !yb_oe_n && !hit_b && !inflight_b;

  assign ya_ready = hit_a;
  assign yb_ready = hit_b;
  assign ya_data  = ya_addr[0] ? word_a[15:8] : word_a[7:0];
  assign yb_data  = yb_addr[0] ? word_b[15:8] : word_b[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    sel        = 1'b0;
    fill       = 1'b0;
    case (state)
      IDLE: begin
        // A mismatched handshake after reset is a stale ack; wait it out
        if ((sdr_req == sdr_ack) && (miss_a || miss_b)) begin
          issue      = 1'b1;
          sel        = (miss_a && miss_b) ? ~last_grant : miss_b;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (sdr_req == sdr_ack) begin
          fill       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdr_req     <= 1'b0;
      sdr_address <= '0;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      fetch_tag   <= '0;
      discard     <= 1'b0;
      valid_a     <= 1'b0;
      valid_b     <= 1'b0;
      tag_a       <= '0;
      tag_b       <= '0;
      word_a      <= '0;
      word_b      <= '0;
    end else begin
      if (issue) begin
        grant       <= sel;
        fetch_tag   <= sel ? yb_addr[23:1] : ya_addr[23:1];
        sdr_address <= sel ? BASE_B + {4'd0, yb_addr[23:1]} : BASE_A + {4'd0, ya_addr[23:1]};
        sdr_req     <= ~sdr_req;
        discard     <= 1'b0;
      end
      if (fill) begin
        last_grant <= grant;
        discard    <= 1'b0;
        if (!flush && !discard) begin
          if (grant) begin
            word_b  <= sdr_data;
            tag_b   <= fetch_tag;
            valid_b <= 1'b1;
          end else begin
            word_a  <= sdr_data;
            tag_a   <= fetch_tag;
            valid_a <= 1'b1;
          end
        end
      end
      // Flush wins over a same-cycle fill and poisons any fetch still in flight
      if (flush) begin
        valid_a <= 1'b0;
        valid_b <= 1'b0;
        if (state == WAIT && !fill) discard <= 1'b1;
      end
    end
  end

endmodule
